// File: rtl/word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : word_serializer
// Brief    : Serializes W-bit words LSB first. Each word is preceded by a
//            one-cycle clear pulse for the downstream stage.
//            Optional macro SER_WORD_CNT_EN adds a 16-bit frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module word_serializer #(
   parameter int W = 8
) (
   input  logic         t_clk,
   input  logic         r,
   input  logic         load_valid,
   input  logic [W-1:0] load_data,
   output logic         load_ready,
   output logic         sd,
   output logic         sclr,
   output logic         sval,
   output logic         slast
`ifdef SER_WORD_CNT_EN
   ,
   output logic [15:0]  word_cnt
`endif
);

   localparam int            CW     = $clog2(W);
   localparam logic [CW-1:0] c_last = CW'(W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      SHIFT = 2'd2
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [W-1:0]  r_shreg, w_shreg_nxt;
   logic          r_rst_hold;
   logic          w_last;
   logic          w_accept;

   // r_rst_hold keeps load_ready low while reset is held, without an
   // input-to-output path.
   assign w_last     = (r_state == SHIFT) && (r_cnt == c_last);
   assign load_ready = ((r_state == IDLE) && !r_rst_hold) || w_last;
   assign w_accept   = load_valid && load_ready;

   always_ff @(posedge t_clk) begin
      if (r) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_shreg    <= '0;
         r_rst_hold <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_shreg    <= w_shreg_nxt;
         r_rst_hold <= 1'b0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_shreg_nxt = r_shreg;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = CLEAR;
               w_shreg_nxt = load_data;
               w_cnt_nxt   = '0;
            end
         end
         CLEAR: begin
            w_state_nxt = SHIFT;
            w_cnt_nxt   = '0;
         end
         SHIFT: begin
            if (r_cnt != c_last) begin
               w_cnt_nxt   = r_cnt + CW'(1);
               w_shreg_nxt = r_shreg >> 1;
            end else if (w_accept) begin
               w_state_nxt = CLEAR;
               w_shreg_nxt = load_data;
               w_cnt_nxt   = '0;
            end else begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      sd    = 1'b0;
      sclr  = 1'b0;
      sval  = 1'b0;
      slast = 1'b0;
      case (r_state)
         CLEAR: sclr = 1'b1;
         SHIFT: begin
            sval  = 1'b1;
            sd    = r_shreg[0];
            slast = w_last;
         end
         default: ;
      endcase
   end

`ifdef SER_WORD_CNT_EN
   logic [15:0] r_word_cnt;

   always_ff @(posedge t_clk) begin
      if (r) begin
         r_word_cnt <= '0;
      end else if (w_last) begin
         r_word_cnt <= r_word_cnt + 16'd1;
      end
   end

   assign word_cnt = r_word_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_word_serializer
// Brief    : Self-checking bench for word_serializer against a queue-based
//            model of the expected serial output stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_word_serializer;

   localparam int W = 8;

   logic         t_clk = 1'b0;
   logic         r = 1'b1;
   logic         load_valid = 1'b0;
   logic [W-1:0] load_data = '0;
   logic         load_ready;
   logic         sd;
   logic         sclr;
   logic         sval;
   logic         slast;
`ifdef SER_WORD_CNT_EN
   logic [15:0]  word_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Expected per-cycle outputs, packed {sclr, sd, sval, slast}
   bit [3:0]    q[$];
   bit          m_rst = 1'b1;
   logic [15:0] m_frames = '0;

   always #5 t_clk = ~t_clk;

   word_serializer #(.W(W)) dut (
      .t_clk      (t_clk),
      .r          (r),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .sd         (sd),
      .sclr       (sclr),
      .sval       (sval),
      .slast      (slast)
`ifdef SER_WORD_CNT_EN
      ,
      .word_cnt   (word_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: compare outputs mid-cycle, drive inputs, advance model.
   task automatic step(input bit rst_i, input bit v, input logic [W-1:0] d);
      bit [3:0] cur;
      bit       rdy;
      @(negedge t_clk);
      cur = (q.size() != 0) ? q[0] : 4'b0000;
      rdy = !m_rst && ((q.size() == 0) || cur[0]);
      check("load_ready", {31'd0, load_ready}, {31'd0, rdy});
      check("sclr",       {31'd0, sclr},       {31'd0, cur[3]});
      check("sd",         {31'd0, sd},         {31'd0, cur[2]});
      check("sval",       {31'd0, sval},       {31'd0, cur[1]});
      check("slast",      {31'd0, slast},      {31'd0, cur[0]});
`ifdef SER_WORD_CNT_EN
      check("word_cnt",   {16'd0, word_cnt},   {16'd0, m_frames});
`endif
      r          = rst_i;
      load_valid = v;
      load_data  = d;
      @(posedge t_clk);
      if (rst_i) begin
         q.delete();
         m_rst    = 1'b1;
         m_frames = '0;
      end else begin
         if (q.size() != 0) begin
            if (cur[0]) m_frames = m_frames + 16'd1;
            void'(q.pop_front());
         end
         if (v && rdy) begin
            q.push_back(4'b1000);
            for (int i = 0; i < W; i++)
               q.push_back({1'b0, d[i], 1'b1, (i == W - 1)});
         end
         m_rst = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, W'($urandom));
   endtask

   initial begin
      // Bring the design out of its unknown power-up state.
      r = 1'b1;
      load_valid = 1'b1;
      @(posedge t_clk);

      // Reset held with load_valid high; ready must rise after release.
      step(1'b1, 1'b1, W'($urandom));
      step(1'b1, 1'b1, W'($urandom));
      idle(2);

      // Single word 8'h0A.
      step(1'b0, 1'b1, 8'h0A);
      idle(12);

      // Back-to-back: 8'h01, then 8'hFF offered exactly in the slast cycle.
      step(1'b0, 1'b1, 8'h01);
      for (int i = 1; i <= 9; i++) step(1'b0, 1'b1, (i == 9) ? 8'hFF : 8'h01);
      idle(12);

      // Mid-frame load pulse while serializing 8'h0F must be ignored.
      step(1'b0, 1'b1, 8'h0F);
      for (int i = 1; i <= 9; i++) step(1'b0, (i == 5), (i == 5) ? 8'h55 : W'($urandom));
      idle(4);

      // Reset after bit 2 of 8'hF0, then a fresh 8'h03.
      step(1'b0, 1'b1, 8'hF0);
      for (int i = 1; i <= 3; i++) step(1'b0, 1'b0, W'($urandom));
      step(1'b1, 1'b1, 8'h77);
      step(1'b0, 1'b0, W'($urandom));
      step(1'b0, 1'b1, 8'h03);
      idle(12);

      // Three counted frames, then wrap from a preloaded 16'hFFFF.
      step(1'b1, 1'b0, '0);
      for (int f = 0; f < 3; f++) begin
         step(1'b0, 1'b1, W'($urandom));
         idle(W + 1);
      end
      idle(2);
`ifdef SER_WORD_CNT_EN
      check("word_cnt_three", {16'd0, word_cnt}, 32'd3);
      @(negedge t_clk);
      force dut.r_word_cnt = 16'hFFFF;
      release dut.r_word_cnt;
      m_frames = 16'hFFFF;
      step(1'b0, 1'b1, W'($urandom));
      idle(W + 2);
      check("word_cnt_wrap", {16'd0, word_cnt}, 32'd0);
`endif

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0), W'($urandom));
      idle(W + 3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
